// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one BCD converter between the ALU path (0) and keypad echo path (1).
// Optional WAIT timeout with error response is enabled by defining BCD_TIMEOUT_EN.
module bcd_conv_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TMO_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic [1:0]  ack,
  output logic [11:0] rsp_digits,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        busy,
  output logic        conv_start,
  output logic [7:0]  conv_a,
  input  logic        conv_done,
  input  logic        conv_valid,
  input  logic [11:0] conv_digits
);

  // Timeout counter must be able to represent TIMEOUT_CYCLES
  if ((2 ** TMO_W) <= TIMEOUT_CYCLES) begin : g_bad_tmo_cfg
    $error("TMO_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t      state, state_n;
  logic        grant, grant_n;
  logic        last_grant, last_grant_n;
  logic [7:0]  conv_a_n;
  logic [11:0] rsp_digits_n;
  logic        rsp_valid_n, rsp_err_n;
  logic [1:0]  ack_n;
  logic        conv_start_n, busy_n;

`ifdef BCD_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
`endif

  // Next state, grant, and next values of every registered output
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    conv_a_n     = conv_a;
    rsp_digits_n = rsp_digits;
    rsp_valid_n  = rsp_valid;
    rsp_err_n    = rsp_err;
`ifdef BCD_TIMEOUT_EN
    tmo_cnt_n    = tmo_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant_n  = (req == 2'b11) ? ~last_grant : req[1];
          conv_a_n = grant_n ? data1 : data0;
          state_n  = S_START;
        end
      end
      S_START: begin
`ifdef BCD_TIMEOUT_EN
        tmo_cnt_n = '0;
`endif
        state_n = S_WAIT;
      end
      S_WAIT: begin
        // conv_done has priority over a timeout in the same cycle
        if (conv_done) begin
          rsp_digits_n = conv_digits;
          rsp_valid_n  = conv_valid;
          rsp_err_n    = 1'b0;
          state_n      = S_RESP;
        end
`ifdef BCD_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          rsp_digits_n = 12'h000;
          rsp_valid_n  = 1'b0;
          rsp_err_n    = 1'b1;
          state_n      = S_RESP;
        end else begin
          tmo_cnt_n = tmo_cnt + TMO_W'(1);
        end
`endif
      end
      S_RESP: begin
        last_grant_n = grant;
        state_n      = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    ack_n        = (state_n == S_RESP) ? {grant, ~grant} : 2'b00;
    conv_start_n = (state_n == S_START);
    busy_n       = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      conv_a     <= 8'h00;
      rsp_digits <= 12'h000;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      ack        <= 2'b00;
      conv_start <= 1'b0;
      busy       <= 1'b0;
`ifdef BCD_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      conv_a     <= conv_a_n;
      rsp_digits <= rsp_digits_n;
      rsp_valid  <= rsp_valid_n;
      rsp_err    <= rsp_err_n;
      ack        <= ack_n;
      conv_start <= conv_start_n;
      busy       <= busy_n;
`ifdef BCD_TIMEOUT_EN
      tmo_cnt    <= tmo_cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter with a behavioural BCD converter stub.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [7:0]  data0, data1;
  logic [1:0]  ack;
  logic [11:0] rsp_digits;
  logic        rsp_valid, rsp_err, busy, conv_start;
  logic [7:0]  conv_a;
  logic        conv_done, conv_valid;
  logic [11:0] conv_digits;

  logic        model_done = 1'b0;
  logic        spur_done = 1'b0;
  logic [11:0] model_digits = 12'h000;
  logic        conv_en = 1'b1;
  int          conv_k = 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  ack;
    logic [11:0] dig;
    logic        valid;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  bcd_conv_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .rsp_digits(rsp_digits), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .busy(busy), .conv_start(conv_start), .conv_a(conv_a),
    .conv_done(conv_done), .conv_valid(conv_valid), .conv_digits(conv_digits)
  );

  always #5 clk = ~clk;

  assign conv_done   = model_done | spur_done;
  assign conv_valid  = model_done;
  assign conv_digits = model_done ? model_digits : 12'hEEE;

  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    int h, t, u;
    h = int'(v) / 100;
    t = (int'(v) / 10) % 10;
    u = int'(v) % 10;
    return {4'(h), 4'(t), 4'(u)};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] a, input logic [11:0] d, input logic v, input logic e);
    exp_t x;
    x.ack = a; x.dig = d; x.valid = v; x.err = e;
    exp_q.push_back(x);
  endtask

  // Waits (bounded) for the next ack; cyc is the number of falling edges taken
  task automatic wait_ack(input int budget, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == 2'b00 && cyc < budget);
    check_eq("ack_seen", 32'(ack != 2'b00), 32'd1);
  endtask

  // Converter stub: done first high k cycles after the start pulse
  always @(posedge clk) begin
    if (conv_start && conv_en) begin
      repeat (conv_k - 1) @(posedge clk);
      #1;
      model_digits = to_bcd(conv_a);
      model_done   = 1'b1;
      @(posedge clk);
      #1;
      model_done   = 1'b0;
    end
  end

  // Scoreboard: every ack pulse must match the oldest expected response
  always @(negedge clk) begin
    if (reset && ack != 2'b00) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check_eq("ack", 32'(ack), 32'(x.ack));
        check_eq("rsp_digits", 32'(rsp_digits), 32'(x.dig));
        check_eq("rsp_valid", 32'(rsp_valid), 32'(x.valid));
        check_eq("rsp_err", 32'(rsp_err), 32'(x.err));
      end
    end
  end

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_ack"}, 32'(ack), 32'd0);
    check_eq({pfx, "_conv_start"}, 32'(conv_start), 32'd0);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_conv_a"}, 32'(conv_a), 32'd0);
    check_eq({pfx, "_rsp_digits"}, 32'(rsp_digits), 32'd0);
    check_eq({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({pfx, "_rsp_err"}, 32'(rsp_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2, c3;
    int hang_cycles;
`ifdef BCD_TIMEOUT_EN
    hang_cycles = 10;
`else
    hang_cycles = 200;
`endif
    reset = 1'b0; req = 2'b00; data0 = 8'h00; data1 = 8'h00;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Single requester 0, k=3: start at N+1, ack at N+5
    data0 = 8'd255; req = 2'b01; conv_k = 3;
    push_exp(2'b01, 12'h255, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("t1_conv_start", 32'(conv_start), 32'd1);
    check_eq("t1_conv_a", 32'(conv_a), 32'd255);
    check_eq("t1_busy", 32'(busy), 32'd1);
    wait_ack(20, c1);
    check_eq("t1_latency", 32'(c1), 32'd4);
    req = 2'b00;
    @(negedge clk);
    check_eq("t1_ack_one_cycle", 32'(ack), 32'd0);
    check_eq("t1_busy_idle", 32'(busy), 32'd0);
    check_eq("t1_digits_hold", 32'(rsp_digits), 32'h255);

    // Requester 1, req dropped after START still gets its ack
    data1 = 8'd42; req = 2'b10; conv_k = 2;
    push_exp(2'b10, 12'h042, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("t3_conv_start", 32'(conv_start), 32'd1);
    req = 2'b00;
    wait_ack(20, c1);
    check_eq("t3_latency", 32'(c1), 32'd3);
    @(negedge clk);
    check_eq("t3_digits_hold", 32'(rsp_digits), 32'h042);
    check_eq("t3_conv_a_hold", 32'(conv_a), 32'd42);

    // Spurious conv_done in IDLE and START is ignored
    spur_done = 1'b1;
    @(negedge clk);
    check_eq("spur_idle_busy", 32'(busy), 32'd0);
    check_eq("spur_idle_start", 32'(conv_start), 32'd0);
    check_eq("spur_idle_digits", 32'(rsp_digits), 32'h042);
    data0 = 8'd99; req = 2'b01; conv_k = 2;
    push_exp(2'b01, 12'h099, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("spur_start_pulse", 32'(conv_start), 32'd1);
    spur_done = 1'b0;
    @(negedge clk);
    check_eq("spur_start_no_ack", 32'(ack), 32'd0);
    check_eq("spur_start_busy", 32'(busy), 32'd1);
    check_eq("spur_start_digits", 32'(rsp_digits), 32'h042);
    wait_ack(20, c1);
    check_eq("spur_latency", 32'(c1), 32'd2);
    req = 2'b00;
    @(negedge clk);

`ifdef BCD_TIMEOUT_EN
    // No conv_done: error response after 64 WAIT cycles
    conv_en = 1'b0; data1 = 8'd200; req = 2'b10;
    push_exp(2'b10, 12'h000, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("tmo_conv_start", 32'(conv_start), 32'd1);
    wait_ack(100, c1);
    check_eq("tmo_latency", 32'(c1), 32'd65);
    req = 2'b00;
    @(negedge clk);
    conv_en = 1'b1;
`endif

    // Reset during WAIT aborts with no ack
    conv_en = 1'b0; data0 = 8'd55; req = 2'b01;
    @(negedge clk);
    check_eq("rst_conv_start", 32'(conv_start), 32'd1);
    repeat (hang_cycles) @(negedge clk);
    check_eq("rst_still_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_mid");
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    conv_en = 1'b1;
    @(negedge clk);

    // Both requesting after reset: 0, 1, 0 back to back at one per (3+k)
    data0 = 8'd7; data1 = 8'd128; req = 2'b11; conv_k = 1;
    push_exp(2'b01, 12'h007, 1'b1, 1'b0);
    push_exp(2'b10, 12'h128, 1'b1, 1'b0);
    push_exp(2'b01, 12'h007, 1'b1, 1'b0);
    wait_ack(20, c1);
    wait_ack(20, c2);
    wait_ack(20, c3);
    req = 2'b00;
    check_eq("rr_first_latency", 32'(c1), 32'd3);
    check_eq("rr_period_2", 32'(c2), 32'd4);
    check_eq("rr_period_3", 32'(c3), 32'd4);
    @(negedge clk);
    check_eq("rr_busy_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
Shares one BCD converter between two requesters: requester 0 is the ALU result path and requester 1 is the keypad echo path.
- Arbitrates round-robin and loads the winner's 8-bit operand.
- Issues a one-cycle start pulse and waits for the converter's done.
- Returns the three BCD digits to the winner with a one-cycle ack.
- Sits between the calculator datapath and the BCD converter inside the SoC peripheral space.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before an error response (used only with BCD_TIMEOUT_EN).
TMO_W, 7, width of the timeout counter; must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
req  input  2  request per requester; held high until the matching ack bit pulses.
data0  input  8  operand of requester 0; must be stable while req[0]=1.
data1  input  8  operand of requester 1; must be stable while req[1]=1.
ack  output  2  one-cycle completion pulse to the granted requester.
rsp_digits  output  12  {hundreds, tens, units} BCD digits of the last conversion.
rsp_valid  output  1  converter valid flag captured with the digits.
rsp_err  output  1  conversion timed out (0 unless BCD_TIMEOUT_EN).
busy  output  1  high in every state except IDLE.
conv_start  output  1  one-cycle start pulse to the converter.
conv_a  output  8  operand presented to the converter.
conv_done  input  1  converter done.
conv_valid  input  1  converter valid.
conv_digits  input  12  converter digits, hundreds in [11:8].

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state=IDLE; ack=0; conv_start=0; busy=0.
  - conv_a=0; rsp_digits=0; rsp_valid=0; rsp_err=0.
  - last_grant=1, so requester 0 wins the first tie.
- Reset mid-operation aborts immediately; no ack is issued. Requesters re-request after reset.
- State machine, one transition per clock:
  - IDLE: if req!=0, pick the winner, set grant, load conv_a from the winner's data, go to START. Otherwise stay.
  - START: conv_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: conv_done is sampled only here.
    - On conv_done=1: latch conv_digits into rsp_digits, conv_valid into rsp_valid, set rsp_err=0; go to RESP.
  - RESP: ack[grant]=1 for exactly this cycle; last_grant<=grant; go to IDLE.
- Arbitration:
  - A single requester wins directly.
  - If both request, grant the requester that is not last_grant.
  - The grant is fixed from IDLE until RESP completes.
- Latency: req sampled in IDLE at cycle N.
  - conv_start is high in cycle N+1.
  - With conv_done first high in cycle N+1+k (k>=1), ack is high in cycle N+2+k.
- A request seen in IDLE immediately after RESP is serviced with no idle gap; back-to-back throughput is one conversion per (3+k) cycles.
- Deasserting req after grant does not abort; the ack is still issued.
- A request arriving during busy waits, and the pending requester is served next.
- rsp_digits, rsp_valid and rsp_err hold their values until the next WAIT exit.
- conv_done outside WAIT is ignored.
- conv_a holds its value after START until the next grant.

Optional Feature:
Macro BCD_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter increments every WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without conv_done: rsp_digits=12'h000, rsp_valid=0, rsp_err=1, go to RESP (ack is still pulsed).
  - conv_done and timeout in the same cycle: conv_done wins.
- Undefined: no counter is built; WAIT waits indefinitely; rsp_err is tied to 0.

Test Plan:
- Reset then req=2'b01, data0=8'd255, converter done after k=3 with digits 12'h255 -> conv_start at N+1, ack=2'b01 at N+5, rsp_digits=12'h255, rsp_valid=1.
- req=2'b11 with data0=8'd7, data1=8'd128, held -> first ack=2'b01 with 12'h007, then ack=2'b10 with 12'h128, then (both still requesting) ack=2'b01 again.
- req=2'b10 with data1=8'd42, req dropped the cycle after START -> ack=2'b10 still pulses, rsp_digits=12'h042.
- Reset pulled low during WAIT -> all outputs 0 within the same cycle, no ack; next req=2'b11 grants requester 0.
- Spurious conv_done in IDLE and START -> ignored, no state change, rsp_digits unchanged.
- BCD_TIMEOUT_EN, TIMEOUT_CYCLES=64, conv_done never asserted -> ack after 64 WAIT cycles with rsp_err=1, rsp_valid=0, rsp_digits=12'h000; without the macro, busy stays 1 indefinitely.
